// File: rtl/spi_slave.sv
// SPI target controller: oversamples SCLK/CS_N/MOSI on clk_i, deserialises MOSI
// into an RX FIFO and serialises bytes from a TX FIFO onto MISO.
// Supports CPOL/CPHA modes 0-3 and MSB- or LSB-first bit order.
module spi_slave #(
    parameter int unsigned RX_BUFFER_SIZE = 16,
    parameter int unsigned TX_BUFFER_SIZE = 16,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic       clock_pol_i,
    input  logic       clock_pha_i,
    input  logic       bit_order_i,
    input  logic       tx_write_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_full_o,
    input  logic       rx_read_i,
    output logic [7:0] rx_data_o,
    output logic       rx_empty_o,
    input  logic       clear_errors_i,
    output logic       rx_overrun_o,
    output logic       tx_underrun_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       interrupt_o
);

    localparam int unsigned RX_AW = $clog2(RX_BUFFER_SIZE);
    localparam int unsigned TX_AW = $clog2(TX_BUFFER_SIZE);
    localparam logic [RX_AW:0] RX_DEPTH = (RX_AW + 1)'(RX_BUFFER_SIZE);
    localparam logic [TX_AW:0] TX_DEPTH = (TX_AW + 1)'(TX_BUFFER_SIZE);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // pin synchronisers and edge history
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_hist, cs_hist;
    logic                   sclk_s, cs_s, mosi_s;

    // frame state
    state_t     state;
    logic       cpol_q, cpha_q, order_q;
    logic [2:0] bit_cnt;
    logic       load_pending;
    logic [7:0] tx_shift, rx_shift;
    logic       rx_push;
    logic [7:0] rx_byte;

    // FIFO storage
    logic [7:0]       rx_mem [RX_BUFFER_SIZE];
    logic [RX_AW-1:0] rx_wr, rx_rd;
    logic [RX_AW:0]   rx_count;
    logic [7:0]       tx_mem [TX_BUFFER_SIZE];
    logic [TX_AW-1:0] tx_wr, tx_rd;
    logic [TX_AW:0]   tx_count;

    // decoded events
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic       lead_edge, trail_edge, sample_edge, shift_edge;
    logic       frame_start, frame_end, do_sample, do_shift, byte_done;
    logic       tx_load, tx_pop, tx_empty, tx_wr_en;
    logic       load_order;
    logic [7:0] load_byte, rx_next;
    logic       rx_full, rx_wr_en, rx_pop;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign cs_fall   = ~cs_s & cs_hist;
    assign cs_rise   = cs_s & ~cs_hist;

    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    assign frame_start = (state == IDLE) & cs_fall;
    assign frame_end   = (state == ACTIVE) & cs_rise;
    assign do_sample   = (state == ACTIVE) & ~cs_rise & sample_edge;
    assign do_shift    = (state == ACTIVE) & ~cs_rise & shift_edge;
    assign byte_done   = do_sample & (bit_cnt == 3'd7);

    // CPHA=0 needs its first bit on MISO before the first edge, so it loads at frame start
    assign tx_load    = (frame_start & ~clock_pha_i) | (do_shift & load_pending);
    assign tx_pop     = tx_load & ~tx_empty;
    assign load_byte  = tx_empty ? 8'hFF : tx_mem[tx_rd];
    assign load_order = frame_start ? bit_order_i : order_q;
    assign rx_next    = order_q ? {mosi_s, rx_shift[7:1]} : {rx_shift[6:0], mosi_s};

    assign tx_full_o   = (tx_count == TX_DEPTH);
    assign tx_empty    = (tx_count == '0);
    assign tx_wr_en    = tx_write_i & ~tx_full_o;
    assign rx_full     = (rx_count == RX_DEPTH);
    assign rx_empty_o  = (rx_count == '0);
    assign rx_wr_en    = rx_push & ~rx_full;
    assign rx_pop      = rx_read_i & ~rx_empty_o;
    assign rx_data_o   = rx_mem[rx_rd];
    assign interrupt_o = ~rx_empty_o | rx_overrun_o | tx_underrun_o;

    // bring asynchronous SPI pins into the clk_i domain and keep one cycle of history
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_hist <= 1'b0;
            cs_hist   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_hist <= sclk_s;
            cs_hist   <= cs_s;
        end
    end

    // frame FSM: mode latching, TX shift/load, RX sampling and registered pin outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            order_q      <= 1'b0;
            bit_cnt      <= '0;
            load_pending <= 1'b0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            rx_push      <= 1'b0;
            rx_byte      <= '0;
            miso_o       <= 1'b0;
            miso_oe_o    <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            // a completed byte is pushed even if CS_N rises right after it
            rx_push      <= byte_done;
            if (byte_done) begin
                rx_byte <= rx_next;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state        <= ACTIVE;
                        cpol_q       <= clock_pol_i;
                        cpha_q       <= clock_pha_i;
                        order_q      <= bit_order_i;
                        busy_o       <= 1'b1;
                        miso_oe_o    <= 1'b1;
                        bit_cnt      <= '0;
                        load_pending <= clock_pha_i;
                        if (tx_load) begin
                            tx_shift <= load_byte;
                            miso_o   <= load_order ? load_byte[0] : load_byte[7];
                        end
                    end
                end
                ACTIVE: begin
                    if (frame_end) begin
                        state        <= IDLE;
                        busy_o       <= 1'b0;
                        miso_oe_o    <= 1'b0;
                        miso_o       <= 1'b0;
                        bit_cnt      <= '0;
                        load_pending <= 1'b0;
                        frame_done_o <= 1'b1;
                    end else begin
                        if (do_shift) begin
                            if (load_pending) begin
                                tx_shift     <= load_byte;
                                miso_o       <= load_order ? load_byte[0] : load_byte[7];
                                load_pending <= 1'b0;
                            end else begin
                                tx_shift <= order_q ? {1'b0, tx_shift[7:1]} : {tx_shift[6:0], 1'b0};
                                miso_o   <= order_q ? tx_shift[1] : tx_shift[6];
                            end
                        end
                        if (do_sample) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                load_pending <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sticky error flags; a fresh error beats a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_overrun_o  <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            if (rx_push && rx_full) begin
                rx_overrun_o <= 1'b1;
            end else if (clear_errors_i) begin
                rx_overrun_o <= 1'b0;
            end
            if (tx_load && tx_empty) begin
                tx_underrun_o <= 1'b1;
            end else if (clear_errors_i) begin
                tx_underrun_o <= 1'b0;
            end
        end
    end

    // TX FIFO storage (contents are only read while occupied)
    always_ff @(posedge clk_i) begin
        if (tx_wr_en) begin
            tx_mem[tx_wr] <= tx_data_i;
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_wr_en) begin
                tx_wr <= tx_wr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd <= tx_rd + 1'b1;
            end
            case ({tx_wr_en, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // RX FIFO storage, cleared so the head reads zero out of reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_mem <= '{default: '0};
        end else if (rx_wr_en) begin
            rx_mem[rx_wr] <= rx_byte;
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_wr_en) begin
                rx_wr <= rx_wr + 1'b1;
            end
            if (rx_pop) begin
                rx_rd <= rx_rd + 1'b1;
            end
            case ({rx_wr_en, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as the SPI master at clk/8 and checks
// MISO data, RX FIFO contents, error flags, frame status and reset behaviour.
module tb_spi_slave;

    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic       cpol = 1'b0, cpha = 1'b0, order = 1'b0;
    logic       tx_write = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_full;
    logic       rx_read = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       clear_errors = 1'b0;
    logic       rx_overrun, tx_underrun, busy, frame_done, irq;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int fd_cnt = 0;
    int fd_before;
    logic [7:0] mi;

    spi_slave #(
        .RX_BUFFER_SIZE(16),
        .TX_BUFFER_SIZE(16),
        .SYNC_STAGES   (2)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .sclk_i        (sclk),
        .cs_n_i        (cs_n),
        .mosi_i        (mosi),
        .miso_o        (miso),
        .miso_oe_o     (miso_oe),
        .clock_pol_i   (cpol),
        .clock_pha_i   (cpha),
        .bit_order_i   (order),
        .tx_write_i    (tx_write),
        .tx_data_i     (tx_data),
        .tx_full_o     (tx_full),
        .rx_read_i     (rx_read),
        .rx_data_o     (rx_data),
        .rx_empty_o    (rx_empty),
        .clear_errors_i(clear_errors),
        .rx_overrun_o  (rx_overrun),
        .tx_underrun_o (tx_underrun),
        .busy_o        (busy),
        .frame_done_o  (frame_done),
        .interrupt_o   (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge clk);
        tx_write = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_write = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk);
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge clk);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic ord);
        cpol  = pol;
        cpha  = pha;
        order = ord;
        sclk  = pol;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        #HALF;
    endtask

    task automatic frame_end();
        #HALF;
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // master side of nbits bit periods; mi collects what MISO presented
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] got);
        logic [2:0] idx;
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = order ? 3'(i) : 3'(7 - i);
            if (!cpha) begin
                mosi = mo[idx];
                #HALF;
                got[idx] = miso;
                sclk = ~cpol;
                #HALF;
                sclk = cpol;
            end else begin
                #HALF;
                sclk = ~cpol;
                mosi = mo[idx];
                #HALF;
                got[idx] = miso;
                sclk = cpol;
            end
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_empty", 32'(rx_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_outputs", {22'd0, miso, miso_oe, tx_full, rx_overrun, tx_underrun, busy, frame_done, irq, rx_empty, 1'b0},
              32'h2);
        check("rst_rx_data", 32'(rx_data), 32'h00);

        // 1: mode 0 MSB first, TX 0xA5, master sends 0x3C
        set_mode(1'b0, 1'b0, 1'b0);
        push_tx(8'hA5);
        fd_before = fd_cnt;
        frame_begin();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_oe", 32'(miso_oe), 32'd1);
        xfer(8'h3C, 8, mi);
        frame_end();
        check("t1_miso", 32'(mi), 32'hA5);
        check("t1_frame_done", 32'(fd_cnt - fd_before), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_oe_end", 32'(miso_oe), 32'd0);
        check("t1_rx_empty", 32'(rx_empty), 32'd0);
        check("t1_rx_data", 32'(rx_data), 32'h3C);
        // mode 0 reloads on the trailing edge after the 8th bit, finding TX empty
        check("t1_underrun", 32'(tx_underrun), 32'd1);
        pop_rx();
        check("t1_rx_empty_pop", 32'(rx_empty), 32'd1);
        clear_err();
        check("t1_irq_clear", 32'(irq), 32'd0);

        // 2: mode 3 LSB first, TX 0x55,0xAA, one frame sends 0x01,0x80
        set_mode(1'b1, 1'b1, 1'b1);
        push_tx(8'h55);
        push_tx(8'hAA);
        frame_begin();
        xfer(8'h01, 8, mi);
        check("t2_miso0", 32'(mi), 32'h55);
        xfer(8'h80, 8, mi);
        check("t2_miso1", 32'(mi), 32'hAA);
        frame_end();
        check("t2_rx0", 32'(rx_data), 32'h01);
        pop_rx();
        check("t2_rx1", 32'(rx_data), 32'h80);
        pop_rx();
        check("t2_rx_empty", 32'(rx_empty), 32'd1);
        check("t2_underrun", 32'(tx_underrun), 32'd0);

        // 3: mode 1, TX empty, master sends 0x00
        set_mode(1'b0, 1'b1, 1'b0);
        frame_begin();
        xfer(8'h00, 8, mi);
        frame_end();
        check("t3_miso", 32'(mi), 32'hFF);
        check("t3_underrun", 32'(tx_underrun), 32'd1);
        check("t3_rx", 32'(rx_data), 32'h00);
        pop_rx();
        check("t3_irq", 32'(irq), 32'd1);
        clear_err();
        check("t3_underrun_clr", 32'(tx_underrun), 32'd0);
        check("t3_irq_clr", 32'(irq), 32'd0);

        // 4: 17 bytes into a 16-deep RX FIFO
        set_mode(1'b0, 1'b0, 1'b0);
        frame_begin();
        for (int k = 0; k < 17; k++) begin
            xfer(8'(8'h10 + k), 8, mi);
        end
        frame_end();
        check("t4_overrun", 32'(rx_overrun), 32'd1);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t4_rx%0d", k), 32'(rx_data), 32'(8'h10 + k));
            pop_rx();
        end
        check("t4_rx_empty", 32'(rx_empty), 32'd1);
        clear_err();
        check("t4_overrun_clr", 32'(rx_overrun), 32'd0);

        // 5: frame aborted after 5 bits, then a full frame of 0x81
        fd_before = fd_cnt;
        frame_begin();
        xfer(8'hF0, 5, mi);
        frame_end();
        check("t5_abort_done", 32'(fd_cnt - fd_before), 32'd1);
        check("t5_abort_empty", 32'(rx_empty), 32'd1);
        frame_begin();
        xfer(8'h81, 8, mi);
        frame_end();
        check("t5_rx", 32'(rx_data), 32'h81);
        pop_rx();
        check("t5_rx_empty", 32'(rx_empty), 32'd1);
        clear_err();

        // 6: TX full boundary, then reset in the middle of a byte
        for (int k = 0; k < 16; k++) begin
            push_tx(8'(8'hC0 + k));
        end
        check("t6_tx_full", 32'(tx_full), 32'd1);
        frame_begin();
        xfer(8'h5A, 8, mi);
        check("t6_miso", 32'(mi), 32'hC0);
        xfer(8'h33, 4, mi);
        check("t6_pre_busy", 32'(busy), 32'd1);
        check("t6_pre_rx_empty", 32'(rx_empty), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {22'd0, miso, miso_oe, tx_full, rx_overrun, tx_underrun, busy, frame_done, irq, rx_empty, 1'b0},
              32'h2);
        check("t6_rst_rx_data", 32'(rx_data), 32'h00);
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_post_rx_empty", 32'(rx_empty), 32'd1);
        check("t6_post_tx_full", 32'(tx_full), 32'd0);
        set_mode(1'b0, 1'b1, 1'b0);
        frame_begin();
        xfer(8'h00, 8, mi);
        frame_end();
        check("t6_post_tx_empty", 32'(mi), 32'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
